rv32im_mdu: RTL and testbench

- Parametrised, multi-cycle multiply/divide unit. Successor to the single-cycle ALU multiply path in rv32im_exu.
- Executes all eight RV32M operations on XLEN-wide operands.
- Uses valid/ready request and response handshakes, a tag passthrough and a flush input, so the EXU can issue to it and stall or kill on pipeline events.
- Sits beside the EXU ALU. The EXU's data_o mux selects res_o when resp_valid_o is high.

---
 rtl/rv32im_mdu.sv | 182 ++++++++++++++++++
 tb/tb_rv32im_mdu.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/rv32im_mdu.sv
// Multi-cycle RV32M multiply/divide unit: shift-add multiply (MUL_STEP bits/cycle), restoring divide.
// Latency N+2 edges (1 for div-by-zero/overflow); result held in DONE until resp_ready_i, flush aborts.
module rv32im_mdu #(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1,
  parameter int TAG_W    = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       op_i,
  input  logic [XLEN-1:0]  rs1_i,
  input  logic [XLEN-1:0]  rs2_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [XLEN-1:0]  res_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             busy_o
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(XLEN / MUL_STEP - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic                neg_q, neg_d;
  logic                rneg_q, rneg_d;
  logic [XLEN-1:0]     res_q, res_d;
  logic [TAG_W-1:0]    tag_q, tag_d;

  logic                sgn_a, sgn_b, a_neg, b_neg, div0, ovf, accept;
  logic [XLEN-1:0]     a_mag, b_mag, fast_res;

  // Operand decode at accept: only magnitudes and sign flags are retained.
  always_comb begin
    sgn_a    = (op_i == 3'b001) || (op_i == 3'b010) || (op_i == 3'b100) || (op_i == 3'b110);
    sgn_b    = (op_i == 3'b001) || (op_i == 3'b100) || (op_i == 3'b110);
    a_neg    = sgn_a && rs1_i[XLEN-1];
    b_neg    = sgn_b && rs2_i[XLEN-1];
    a_mag    = a_neg ? -rs1_i : rs1_i;
    b_mag    = b_neg ? -rs2_i : rs2_i;
    div0     = op_i[2] && (rs2_i == '0);
    ovf      = op_i[2] && !op_i[0] && (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);
    fast_res = op_i[1] ? (div0 ? rs1_i : '0) : (div0 ? '1 : rs1_i);
    accept   = (state_q == S_IDLE) && req_valid_i && !flush_i;
  end

  logic [XLEN+MUL_STEP-1:0] mul_pp, mul_sum;
  logic [2*XLEN-1:0]        mul_nxt;

  // acc_q = {partial product high, remaining multiplier bits}; shifts right MUL_STEP per cycle.
  always_comb begin
    mul_pp = '0;
    for (int k = 0; k < MUL_STEP; k++) begin
      if (acc_q[k]) mul_pp = mul_pp + ({{MUL_STEP{1'b0}}, opnd_q} << k);
    end
    mul_sum = {{MUL_STEP{1'b0}}, acc_q[2*XLEN-1:XLEN]} + mul_pp;
    mul_nxt = {mul_sum, acc_q[XLEN-1:MUL_STEP]};
  end

  logic [XLEN:0]     div_sh;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem;
  logic [2*XLEN-1:0] div_nxt;

  // acc_q = {partial remainder, dividend bits shifting out / quotient bits shifting in}.
  always_comb begin
    div_sh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge  = div_sh >= {1'b0, opnd_q};
    div_rem = div_ge ? (div_sh[XLEN-1:0] - opnd_q) : div_sh[XLEN-1:0];
    div_nxt = {div_rem, acc_q[XLEN-2:0], div_ge};
  end

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fix_res;

  always_comb begin
    prod_s = neg_q ? -acc_q : acc_q;
    quo_s  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_s  = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    if (op_q[2])              fix_res = op_q[1] ? rem_s : quo_s;
    else if (op_q[1:0] == 2'b00) fix_res = prod_s[XLEN-1:0];
    else                      fix_res = prod_s[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    res_d   = res_q;
    tag_d   = tag_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d   = op_i;
          tag_d  = tag_i;
          neg_d  = a_neg ^ b_neg;
          rneg_d = a_neg;
          cnt_d  = '0;
          if (div0 || ovf) begin
            res_d   = fast_res;
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
            if (op_i[2]) begin
              opnd_d = b_mag;
              acc_d  = {{XLEN{1'b0}}, a_mag};
            end else begin
              opnd_d = a_mag;
              acc_d  = {{XLEN{1'b0}}, b_mag};
            end
          end
        end
      end
      S_CALC: begin
        acc_d = op_q[2] ? div_nxt : mul_nxt;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == (op_q[2] ? DIV_LAST : MUL_LAST)) begin
          cnt_d   = '0;
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        res_d   = fix_res;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (resp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Flush kills anything in flight and outranks resp_ready_i.
    if (flush_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      res_q   <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      res_q   <= res_d;
      tag_q   <= tag_d;
    end
  end

  assign req_ready_o  = (state_q == S_IDLE);
  assign resp_valid_o = (state_q == S_DONE);
  assign busy_o       = (state_q != S_IDLE);
  assign res_o        = res_q;
  assign tag_o        = tag_q;

endmodule

// File: tb/tb_rv32im_mdu.sv
// Directed-vector bench for rv32im_mdu: table of RV32M ops plus handshake, flush and reset sequences.
module tb_rv32im_mdu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, flush, resp_valid, resp_ready, busy;
  logic [2:0]  op;
  logic [31:0] rs1, rs2, res;
  logic [4:0]  tag, tag_out;

  logic        u4_req_valid, u4_req_ready, u4_resp_valid, u4_resp_ready, u4_busy;
  logic [2:0]  u4_op;
  logic [31:0] u4_rs1, u4_rs2, u4_res;
  logic [4:0]  u4_tag, u4_tag_out;

  always #5 clk = ~clk;

  rv32im_mdu #(.XLEN(32), .MUL_STEP(1), .TAG_W(5)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .op_i(op), .rs1_i(rs1), .rs2_i(rs2), .tag_i(tag), .flush_i(flush),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .res_o(res),
    .tag_o(tag_out), .busy_o(busy)
  );

  rv32im_mdu #(.XLEN(32), .MUL_STEP(4), .TAG_W(5)) dut4 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(u4_req_valid), .req_ready_o(u4_req_ready),
    .op_i(u4_op), .rs1_i(u4_rs1), .rs2_i(u4_rs2), .tag_i(u4_tag), .flush_i(1'b0),
    .resp_valid_o(u4_resp_valid), .resp_ready_i(u4_resp_ready), .res_o(u4_res),
    .tag_o(u4_tag_out), .busy_o(u4_busy)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  // Issue one request and wait (bounded) for resp_valid; caller is positioned 1 time unit after a posedge.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] t, output logic [31:0] r, output logic [4:0] rt,
                        output int lat);
    int w = 0;
    while (!req_ready && w < 100) begin
      @(posedge clk); #1; w++;
    end
    req_valid = 1'b1; op = o; rs1 = a; rs2 = b; tag = t;
    @(posedge clk); #1;
    req_valid = 1'b0; rs1 = $urandom; rs2 = $urandom; tag = 5'($urandom);
    lat = 1;
    while (!resp_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    r = res; rt = tag_out;
  endtask

  task automatic pulse_ready();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  vec_t        vecs[20];
  logic [31:0] r;
  logic [4:0]  rt;
  int          lat;
  logic        seen;

  initial begin
    vecs[0]  = '{3'b000, 32'd6,        32'd100,      32'd600,      34};
    vecs[1]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34};
    vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34};
    vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34};
    vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34};
    vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34};
    vecs[6]  = '{3'b101, 32'd100,      32'd7,        32'd14,       34};
    vecs[7]  = '{3'b111, 32'd100,      32'd7,        32'd2,        34};
    vecs[8]  = '{3'b100, 32'd123,      32'd0,        32'hFFFFFFFF, 1};
    vecs[9]  = '{3'b111, 32'd55,       32'd0,        32'd55,       1};
    vecs[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
    vecs[12] = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        34};
    vecs[13] = '{3'b001, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 34};
    vecs[14] = '{3'b000, 32'd0,        32'd12345,    32'd0,        34};
    vecs[15] = '{3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34};
    vecs[16] = '{3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        34};
    vecs[17] = '{3'b101, 32'h80000000, 32'hFFFFFFFF, 32'd0,        34};
    vecs[18] = '{3'b111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34};
    vecs[19] = '{3'b101, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 34};

    rst = 1'b1; req_valid = 1'b0; flush = 1'b0; resp_ready = 1'b0;
    op = '0; rs1 = '0; rs2 = '0; tag = '0;
    u4_req_valid = 1'b0; u4_resp_ready = 1'b0; u4_op = '0; u4_rs1 = '0; u4_rs2 = '0; u4_tag = '0;
    #12;
    check("rst_req_ready",  32'(req_ready),  32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_res",        res,             32'd0);
    check("rst_tag",        32'(tag_out),    32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // MUL_STEP=4 instance: 32/4 + 2 = 10 edges.
    u4_req_valid = 1'b1; u4_op = 3'b000; u4_rs1 = 32'd6; u4_rs2 = 32'd100; u4_tag = 5'd3;
    @(posedge clk); #1;
    u4_req_valid = 1'b0; u4_rs1 = $urandom; u4_rs2 = $urandom;
    lat = 1;
    while (!u4_resp_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    check("step4_lat", 32'(lat),        32'd10);
    check("step4_res", u4_res,          32'd600);
    check("step4_tag", 32'(u4_tag_out), 32'd3);
    u4_resp_ready = 1'b1;
    @(posedge clk); #1;
    u4_resp_ready = 1'b0;

    for (int i = 0; i < 20; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 3), r, rt, lat);
      check($sformatf("vec%0d_res", i), r,        vecs[i].exp);
      check($sformatf("vec%0d_tag", i), 32'(rt),  32'(i + 3));
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      pulse_ready();
    end

    // Backpressure: result and tag must hold while resp_ready_i is low.
    run_op(3'b000, 32'd6, 32'd100, 5'd7, r, rt, lat);
    check("bp_first_res", r, 32'd600);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp%0d_res", c),       res,              32'd600);
      check($sformatf("bp%0d_tag", c),       32'(tag_out),     32'd7);
      check($sformatf("bp%0d_valid", c),     32'(resp_valid),  32'd1);
      check($sformatf("bp%0d_req_ready", c), 32'(req_ready),   32'd0);
    end
    pulse_ready();
    check("bp_after_req_ready", 32'(req_ready),  32'd1);
    check("bp_after_valid",     32'(resp_valid), 32'd0);

    // Flush at CALC cycle 10 of a DIV.
    req_valid = 1'b1; op = 3'b100; rs1 = 32'd1000; rs2 = 32'd3; tag = 5'd9;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("flush_busy_before", 32'(busy), 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy",      32'(busy),       32'd0);
    check("flush_valid",     32'(resp_valid), 32'd0);
    check("flush_req_ready", 32'(req_ready),  32'd1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (resp_valid) seen = 1'b1;
    end
    check("flush_no_resp", 32'(seen), 32'd0);

    // Flush while idle blocks acceptance.
    req_valid = 1'b1; flush = 1'b1; op = 3'b000; rs1 = 32'd2; rs2 = 32'd2;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    check("idle_flush_busy", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a MUL.
    req_valid = 1'b1; op = 3'b000; rs1 = 32'd6; rs2 = 32'd100; tag = 5'd11;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy",      32'(busy),       32'd0);
    check("mid_rst_req_ready", 32'(req_ready),  32'd1);
    check("mid_rst_valid",     32'(resp_valid), 32'd0);
    check("mid_rst_res",       res,             32'd0);
    check("mid_rst_tag",       32'(tag_out),    32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(3'b000, 32'd6, 32'd100, 5'd12, r, rt, lat);
    check("post_rst_res", r,         32'd600);
    check("post_rst_tag", 32'(rt),   32'd12);
    check("post_rst_lat", 32'(lat),  32'd34);
    pulse_ready();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
